// File: rtl/serial_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, start/busy/done handshake.
// Optional macro SERIAL_DIVIDER_DIV0_FAST_EN: adds div_by_zero and a two-cycle divide-by-zero path.
module serial_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef SERIAL_DIVIDER_DIV0_FAST_EN
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`else
    output logic [WIDTH-1:0] remainder
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_raw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             signed_q;
    logic             div0_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
`ifdef SERIAL_DIVIDER_DIV0_FAST_EN
    logic             dbz_q;
`endif

    // Operand magnitudes, taken straight from the ports in the accepting cycle.
    logic             neg_a_d;
    logic             neg_b_d;
    logic [WIDTH-1:0] abs_a_d;
    logic [WIDTH-1:0] abs_b_d;

    assign neg_a_d = is_signed & opA[WIDTH-1];
    assign neg_b_d = is_signed & opB[WIDTH-1];
    assign abs_a_d = neg_a_d ? (~opA + 1'b1) : opA;
    assign abs_b_d = neg_b_d ? (~opB + 1'b1) : opB;

    // One restoring step. A set top bit in the shifted value always exceeds the
    // divisor, so the borrow of the (WIDTH+1)-bit subtract is only meaningful below it.
    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   trial_d;
    logic             fits_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    assign shifted_d = {rem_q, quo_q[WIDTH-1]};
    assign trial_d   = shifted_d - {1'b0, dvs_q};
    assign fits_d    = shifted_d[WIDTH] | ~trial_d[WIDTH];
    assign rem_d     = fits_d ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], fits_d};

    // Sign correction; the magnitude of the most negative dividend wraps back naturally.
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;

    always_comb begin
        q_fix_d = quo_q;
        r_fix_d = rem_q;
        if (div0_q) begin
            q_fix_d = '1;
            r_fix_d = dvd_raw_q;
        end else if (signed_q) begin
            if (sign_a_q ^ sign_b_q) begin
                q_fix_d = ~quo_q + 1'b1;
            end
            if (sign_a_q) begin
                r_fix_d = ~rem_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_raw_q   <= '0;
            cnt_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            signed_q    <= 1'b0;
            div0_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef SERIAL_DIVIDER_DIV0_FAST_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_q     <= '0;
                        quo_q     <= abs_a_d;
                        dvs_q     <= abs_b_d;
                        dvd_raw_q <= opA;
                        sign_a_q  <= neg_a_d;
                        sign_b_q  <= neg_b_d;
                        signed_q  <= is_signed;
                        div0_q    <= (opB == '0);
                        busy_q    <= 1'b1;
`ifdef SERIAL_DIVIDER_DIV0_FAST_EN
                        // Zero divisor bypasses CALC; FIX then waits one cycle before completing.
                        if (opB == '0) begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= S_FIX;
                        end else begin
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= S_CALC;
                        end
`else
                        cnt_q     <= CNT_W'(WIDTH);
                        state_q   <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        quotient_q  <= q_fix_d;
                        remainder_q <= r_fix_d;
`ifdef SERIAL_DIVIDER_DIV0_FAST_EN
                        dbz_q       <= div0_q;
`endif
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef SERIAL_DIVIDER_DIV0_FAST_EN
    assign div_by_zero = dbz_q;
`endif

endmodule

// File: doc/serial_divider.md
Name: serial_divider

Overview:
- Multi-cycle integer divider for the processor datapath. Executes DIV and DIVU.
- Uses radix-2 restoring division, one quotient bit per cycle, with a start/busy/done handshake.
- Sits beside the add/sub/SLT unit in the execute stage. Its quotient and remainder feed the LO/HI registers.
- The pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request a divide; sampled only when busy=0
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- opA  input  WIDTH  dividend
- opB  input  WIDTH  divisor
- busy  output  1  divider occupied; new start ignored
- done  output  1  single-cycle pulse: quotient/remainder valid and updated
- quotient  output  WIDTH  result quotient (LO)
- remainder  output  WIDTH  result remainder (HI)

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0; counter and internal registers cleared. Reset mid-operation aborts it silently; no done follows.
- States:
  - IDLE: on start=1, capture |opA|, |opB|, operand signs, is_signed, divisor-zero flag; counter=WIDTH; go to CALC. Otherwise stay.
  - CALC: each cycle shift {rem,quo} left by 1 and trial-subtract divisor from the upper part (WIDTH+1-bit subtract). If non-negative, keep the difference and set the quotient LSB=1, else 0. Decrement counter; after WIDTH iterations go to FIX.
  - FIX: apply sign correction, write quotient/remainder outputs, assert done next cycle, return to IDLE.
- Magnitudes: for is_signed=1 take two's-complement absolute values; for is_signed=0 use raw bits.
- Sign rules (signed): quotient negated iff signA != signB, truncating toward zero. Remainder takes the sign of the dividend.
- Overflow case −2^(WIDTH−1) / −1: quotient = 0x80000000, remainder = 0 (natural wrap, no flag).
- Divide by zero (opB=0, either mode): quotient = all ones, remainder = opA unmodified. Latency is the same as a normal divide.
- Timing:
  - start sampled at edge E0; busy=1 after E0.
  - CALC occupies edges E1..E_WIDTH; FIX is at edge E_WIDTH+1.
  - At E_WIDTH+1: outputs update, done=1, busy=0.
  - Total busy = WIDTH+1 cycles; done high exactly one cycle.
- Back-to-back: start may be asserted in the same cycle done=1. It is accepted, and done/busy behave as above.
- start while busy=1: ignored, operands not sampled, running operation unaffected.
- quotient/remainder hold their last values until the next FIX; they never change during CALC.
- Operands need not be held stable after the accepting edge.

Optional Feature:
- Macro: SERIAL_DIVIDER_DIV0_FAST_EN.
- Defined: adds output port div_by_zero (1 bit, reset 0).
  - On accepting start with opB=0, skip CALC: go directly to FIX.
  - FIX writes quotient = all ones, remainder = opA, div_by_zero=1; done pulses at edge E2 (busy 2 cycles).
  - div_by_zero is updated on every FIX (0 for nonzero divisor) and held with the results.
- Undefined: no div_by_zero port. Divide by zero runs the full WIDTH+1-cycle sequence with the same numeric result.

Test Plan:
- Reset: resetn=0 mid-CALC of 100/7 -> busy=0, done=0, quotient=0, remainder=0 immediately; no done pulse after release.
- Unsigned: is_signed=0, opA=100, opB=7 -> done exactly 33 cycles after the start edge; quotient=14, remainder=2. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF rem 1.
- Signed sign combinations (is_signed=1):
  - −7/2 -> q=−3 (0xFFFFFFFD), r=−1 (0xFFFFFFFF)
  - 7/−2 -> q=−3, r=1
  - −7/−2 -> q=3, r=−1
  - 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0
- Divide by zero: opA=0x1234, opB=0 (both modes) -> quotient=0xFFFFFFFF, remainder=0x1234. Latency 33 cycles (or 2 cycles with div_by_zero=1 when SERIAL_DIVIDER_DIV0_FAST_EN is defined).
- Handshake:
  - start pulsed with 9/3 while busy -> ignored; first result unchanged and a single done.
  - start held in the done cycle with 9/3 -> accepted; second done 33 cycles later with q=3, r=0.
  - Outputs stable throughout CALC.
